// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan scheduler feeding one shared seven-segment decoder.
// Double-buffered digit values commit only at frame wrap, so a frame never shows a torn value.
module seven_seg_scan_ctrl #(
    parameter int   NUM_DIGITS       = 2,
    parameter int   REFRESH_CNT      = 20000,
    parameter int   BLANK_CNT        = 200,
    parameter logic ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      load,
    output logic [3:0]                s,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [1:0]                digit_idx,
    output logic                      frame_start
);

    localparam int CNT_MAX = (REFRESH_CNT > BLANK_CNT) ? REFRESH_CNT : BLANK_CNT;
    localparam int CNT_W   = (CNT_MAX + 1 > 2) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0]      BLANK_LAST   = CNT_W'(BLANK_CNT - 1);
    localparam logic [CNT_W-1:0]      REFRESH_LAST = CNT_W'(REFRESH_CNT - 1);
    localparam logic [1:0]            IDX_LAST     = 2'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF    = ANODE_ACTIVE_LOW ? '1 : '0;

    typedef enum logic {
        BLANK,
        ON
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [1:0]              idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] active;
    logic                    pending;

    function automatic logic [3:0] nibble(input logic [4*NUM_DIGITS-1:0] v, input int i);
        logic [4*NUM_DIGITS-1:0] t;
        t = v >> (4 * i);
        return t[3:0];
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_on(input logic [1:0] i);
        logic [NUM_DIGITS-1:0] oh;
        oh = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << i;
        return oh ^ ANODE_OFF;
    endfunction

    assign digit_idx = idx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= BLANK;
            cnt         <= '0;
            idx         <= '0;
            anode       <= ANODE_OFF;
            s           <= '0;
            frame_start <= 1'b0;
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= ON;
                        cnt   <= '0;
                        anode <= anode_on(idx);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ON: begin
                    if (cnt == REFRESH_LAST) begin
                        state <= BLANK;
                        cnt   <= '0;
                        anode <= ANODE_OFF;
                        // Next nibble goes out during the blank so the decoder settles first.
                        if (idx == IDX_LAST) begin
                            idx         <= '0;
                            frame_start <= 1'b1;
                            if (pending) begin
                                active  <= shadow;
                                pending <= 1'b0;
                                s       <= nibble(shadow, 0);
                            end else begin
                                s <= nibble(active, 0);
                            end
                        end else begin
                            idx <= idx + 2'd1;
                            s   <= nibble(active, int'(idx) + 1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= BLANK;
            endcase
            // NOTE: non-blocking updates resolve last-write-wins, so a load on the
            // commit edge re-arms pending after the commit above has cleared it.
            if (load) begin
                shadow  <= digits_in;
                pending <= 1'b1;
            end
        end
    end

endmodule
